// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Frame-format definitions shared by the UART transmitter and receiver so
//   both ends agree on data width, default baud divisor and FSM encoding.
//   Contents:
//     UART_DATA_BITS         data bits per frame (LSB first on the line)
//     UART_DEF_CLKS_PER_BIT  default clocks per serial bit (receiver's F/8 clock)
//     uart_state_t           framing FSM states
//     calc_parity()          parity bit for a data byte, even or odd sense
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_DEF_CLKS_PER_BIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Even sense makes data+parity carry an even number of ones; odd inverts it.
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bittimer.sv
// -----------------------------------------------------------------------------
// uart_tx_bittimer
//   Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps on
//   its own, so every bit period is exactly CLKS_PER_BIT clocks.
//   Ports:
//     i_clk      system clock
//     i_reset    asynchronous, active-low reset
//     i_clear    synchronous clear to 0 (has priority over i_enable)
//     i_enable   count this cycle
//     o_bit_end  high on the last clock of a bit period
// -----------------------------------------------------------------------------
module uart_tx_bittimer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign o_bit_end = (count == CNT_LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= o_bit_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   Serial UART transmitter. Accepts a byte over valid/ready and sends one
//   frame: start(0), 8 data bits LSB first, parity, STOP_BITS stop bits (1).
//   A one-entry holding buffer lets the next byte be taken during a frame so
//   frames follow each other with no idle gap.
//   Parameters:
//     CLKS_PER_BIT  clocks per serial bit
//     PARITY_ODD    0 = even parity, 1 = odd parity
//     STOP_BITS     number of stop bits, 1 or 2
//   Ports:
//     i_clk         system clock
//     i_reset       asynchronous, active-low reset (aborts a frame in flight)
//     i_data        byte to send, sampled when i_valid && o_ready
//     i_valid       upstream has a byte on i_data
//     o_ready       holding buffer empty, a byte can be accepted
//     o_txd         registered serial line, idles high
//     o_busy        a frame is on the line
//     o_frame_done  pulse on the last clock of the final stop bit
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_txd,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       ODD       = 1'(PARITY_ODD);

  uart_state_t               state, state_n;
  logic [2:0]                idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic [UART_DATA_BITS-1:0] hold_buf, hold_buf_n;
  logic                      buf_full, buf_full_n;
  logic                      parity_bit, parity_n;
  logic                      txd_q, txd_d;
  logic                      bit_end;
  logic                      accept;
  logic                      frame_end;

  // The timer idles at 0 so the first start-bit period is a full bit time.
  uart_tx_bittimer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bittimer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (state == ST_IDLE),
    .i_enable  (state != ST_IDLE),
    .o_bit_end (bit_end)
  );

  assign o_ready   = !buf_full;
  assign accept    = i_valid && o_ready;
  assign frame_end = (state == ST_STOP) && bit_end && (idx == LAST_STOP);

  // State register and datapath flops.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      shreg      <= '0;
      hold_buf   <= '0;
      buf_full   <= 1'b0;
      parity_bit <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      hold_buf   <= hold_buf_n;
      buf_full   <= buf_full_n;
      parity_bit <= parity_n;
      txd_q      <= txd_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_n    = state;
    idx_n      = idx;
    shreg_n    = shreg;
    hold_buf_n = hold_buf;
    buf_full_n = buf_full;
    parity_n   = parity_bit;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          shreg_n  = i_data;
          parity_n = calc_parity(i_data, ODD);
          state_n  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (idx == LAST_DATA) begin
            state_n = ST_PARITY;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_n = ST_STOP;
          idx_n   = '0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx == LAST_STOP) begin
            idx_n = '0;
            if (buf_full) begin
              // Chain the buffered byte straight into the next start bit.
              shreg_n    = hold_buf;
              parity_n   = calc_parity(hold_buf, ODD);
              buf_full_n = 1'b0;
              state_n    = ST_START;
            end else if (accept) begin
              // Buffer empty: a byte arriving on the final stop edge bypasses it.
              shreg_n  = i_data;
              parity_n = calc_parity(i_data, ODD);
              state_n  = ST_START;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Any other accept while a frame is running lands in the holding buffer.
    if (accept && (state != ST_IDLE) && !frame_end) begin
      hold_buf_n = i_data;
      buf_full_n = 1'b1;
    end
  end

  // Outputs. The line value is computed from the next state so the flopped
  // o_txd changes on the same edge as the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_n)
      ST_IDLE:   txd_d = 1'b1;
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_n[0];
      ST_PARITY: txd_d = parity_n;
      ST_STOP:   txd_d = 1'b1;
      default:   txd_d = 1'b1;
    endcase
    o_busy       = (state != ST_IDLE);
    o_frame_done = frame_end;
  end

  assign o_txd = txd_q;

endmodule
